csi_frame_sequencer: RTL and testbench

- Frame-level controller between lts_extractor and the xfft_0 FFT core in the CSI pipeline.
- Programs the FFT config channel after reset and whenever the runtime config word changes.
- Enforces exactly NFFT samples per frame: pads short frames with zeros and drains long ones.
- Limits frames in flight through FFT + equalizer, and counts frames and errors for software.

---
 rtl/csi_pkg.sv | 26 ++
 rtl/csi_frame_sequencer_sat_counter.sv | 25 ++
 rtl/csi_frame_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_csi_frame_sequencer.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csi_pkg.sv
// Shared types and constants for the CSI frame sequencer.
// No logic: sequencer state encoding, the {Q,I} sample layout, default FFT config word.
// Imported by every file of the sequencer and by its bench.
package csi_pkg;

   // Reference FFT size; the sample counter is CNT_W bits wide at this size.
   localparam int NFFT_DEFAULT = 64;
   localparam int CNT_W        = $clog2(NFFT_DEFAULT);

   // Forward transform with the usual scale schedule for a 64-point core.
   localparam logic [15:0] CSI_FFT_CFG_DEFAULT = 16'h0157;

   typedef enum logic [2:0] {
      CONFIG,
      IDLE,
      STREAM,
      PAD,
      DRAIN
   } seq_state_t;

   typedef struct packed {
      logic [15:0] q;
      logic [15:0] i;
   } iq_t;

endpackage

// File: rtl/csi_frame_sequencer_sat_counter.sv
// Status event counter that either saturates at all-ones or wraps.
// Latency: count reflects an inc one clock later.
// Backpressure: none; every inc is taken.
module sat_counter
   import csi_pkg::*;
#(
   parameter int WIDTH    = 16,
   parameter bit SATURATE = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   // Count up on inc; hold at all-ones when saturating, roll over otherwise.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (inc && !(SATURATE && (&count))) begin
         count <= count + WIDTH'(1);
      end
   end

endmodule

// File: rtl/csi_frame_sequencer.sv
// Frame sequencer between the LTS extractor and the FFT core: configures the FFT, forces NFFT-sample frames.
// Latency: zero-cycle data passthrough while streaming; one idle cycle between frames.
// Backpressure: FFT tready passes straight upstream; upstream is held while configuring or at the in-flight limit.
// Optional watchdog on in-flight frames: define CSI_SEQ_WATCHDOG_EN.
module csi_frame_sequencer
   import csi_pkg::*;
#(
   parameter int NFFT         = NFFT_DEFAULT,
   parameter int MAX_INFLIGHT = 2,
   parameter int CFG_WIDTH    = 16,
   parameter int WDT_CYCLES   = 4096
) (
   input  logic                 clk_in,
   input  logic                 rst_n_in,
   input  logic [CFG_WIDTH-1:0] cfg_word_in,
   input  logic                 lts_axis_tvalid,
   input  logic                 lts_axis_tlast,
   input  logic [31:0]          lts_axis_tdata,
   output logic                 lts_axis_tready,
   output logic                 fft_axis_tvalid,
   output logic                 fft_axis_tlast,
   output logic [31:0]          fft_axis_tdata,
   input  logic                 fft_axis_tready,
   output logic                 cfg_axis_tvalid,
   output logic [CFG_WIDTH-1:0] cfg_axis_tdata,
   input  logic                 cfg_axis_tready,
   input  logic                 csi_done_in,
   output logic [3:0]           inflight_out,
   output logic [15:0]          frame_count_out,
   output logic [15:0]          short_count_out,
   output logic [15:0]          long_count_out,
   output logic                 wdt_err_out
);

   localparam int CW = $clog2(NFFT);

   seq_state_t           state;
   logic [CW-1:0]        cnt;
   logic [CFG_WIDTH-1:0] cfg_shadow;
   logic                 cfg_vld;

   logic                 at_last;
   logic                 up_hs;
   logic                 frame_end;
   logic                 retire;
   logic                 short_evt;
   logic                 long_evt;
   logic                 wdt_fire;
   logic [3:0]           inflight_nxt;
   iq_t                  out_sample;

   assign at_last   = (cnt == CW'(NFFT - 1));
   assign up_hs     = lts_axis_tvalid && lts_axis_tready;
   // fft_axis_tlast is only ever high on sample NFFT-1, so this is the one frame-end event.
   assign frame_end = fft_axis_tvalid && fft_axis_tready && fft_axis_tlast;
   // A retire pulse with nothing outstanding is dropped rather than underflowing.
   assign retire    = csi_done_in && (inflight_out != 4'd0);
   assign short_evt = (state == STREAM) && up_hs && lts_axis_tlast && !at_last;
   assign long_evt  = (state == STREAM) && up_hs && !lts_axis_tlast && at_last;

   assign cfg_axis_tvalid = cfg_vld;
   assign cfg_axis_tdata  = cfg_vld ? cfg_shadow : '0;
   assign fft_axis_tdata  = out_sample;

   // Data-path mux: passthrough while streaming, zero fill while padding, sink while draining.
   always_comb begin
      lts_axis_tready = 1'b0;
      fft_axis_tvalid = 1'b0;
      fft_axis_tlast  = 1'b0;
      out_sample      = '0;
      case (state)
         STREAM: begin
            fft_axis_tvalid = lts_axis_tvalid;
            lts_axis_tready = fft_axis_tready;
            out_sample      = iq_t'(lts_axis_tdata);
            fft_axis_tlast  = at_last;
         end
         PAD: begin
            fft_axis_tvalid = 1'b1;
            fft_axis_tlast  = at_last;
         end
         DRAIN: begin
            lts_axis_tready = 1'b1;
         end
         default: begin
         end
      endcase
   end

   // Next in-flight count: +1 per delivered frame, -1 per retired frame, watchdog flush wins.
   always_comb begin
      inflight_nxt = inflight_out;
      if (frame_end && !retire) begin
         inflight_nxt = inflight_out + 4'd1;
      end else if (!frame_end && retire) begin
         inflight_nxt = inflight_out - 4'd1;
      end
      if (wdt_fire) begin
         inflight_nxt = frame_end ? 4'd1 : 4'd0;
      end
   end

   // Sequencer FSM: config handshake, per-frame sample counting, frame-end bookkeeping.
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         state        <= CONFIG;
         cfg_shadow   <= cfg_word_in;
         cfg_vld      <= 1'b0;
         cnt          <= '0;
         inflight_out <= 4'd0;
      end else begin
         inflight_out <= inflight_nxt;
         case (state)
            CONFIG: begin
               // Valid rises the cycle after entry from reset; shadow is frozen while it is up.
               if (!cfg_vld) begin
                  cfg_vld <= 1'b1;
               end else if (cfg_axis_tready) begin
                  cfg_vld <= 1'b0;
                  state   <= IDLE;
               end
            end
            IDLE: begin
               // Only here, between frames, may a new config word take effect.
               if (cfg_word_in != cfg_shadow) begin
                  cfg_shadow <= cfg_word_in;
                  cfg_vld    <= 1'b1;
                  state      <= CONFIG;
               end else if (inflight_out < 4'(MAX_INFLIGHT)) begin
                  state <= STREAM;
               end
            end
            STREAM: begin
               if (up_hs) begin
                  if (at_last) begin
                     cnt   <= '0;
                     state <= lts_axis_tlast ? IDLE : DRAIN;
                  end else begin
                     cnt <= cnt + CW'(1);
                     if (lts_axis_tlast) begin
                        state <= PAD;
                     end
                  end
               end
            end
            PAD: begin
               if (fft_axis_tready) begin
                  if (at_last) begin
                     cnt   <= '0;
                     state <= IDLE;
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end
            DRAIN: begin
               if (lts_axis_tvalid && lts_axis_tlast) begin
                  state <= IDLE;
               end
            end
            default: begin
               state <= CONFIG;
            end
         endcase
      end
   end

`ifdef CSI_SEQ_WATCHDOG_EN
   localparam int TMR_W = $clog2(WDT_CYCLES + 1);

   logic [TMR_W-1:0] wdt_tmr;
   logic             wdt_err;

   assign wdt_fire    = (inflight_out != 4'd0) && !csi_done_in &&
                        (wdt_tmr == TMR_W'(WDT_CYCLES - 1));
   assign wdt_err_out = wdt_err;

   // Timer runs while frames are outstanding with no retirement; a timeout flushes in-flight and latches the error.
   always_ff @(posedge clk_in) begin
      if (!rst_n_in) begin
         wdt_tmr <= '0;
         wdt_err <= 1'b0;
      end else begin
         if ((inflight_out == 4'd0) || csi_done_in || wdt_fire) begin
            wdt_tmr <= '0;
         end else begin
            wdt_tmr <= wdt_tmr + TMR_W'(1);
         end
         if (wdt_fire) begin
            wdt_err <= 1'b1;
         end
      end
   end
`else
   // Watchdog compiled out: no flush and an error flag that stays low for any WDT_CYCLES.
   localparam logic WDT_TIE = (WDT_CYCLES > 0) ? 1'b0 : 1'b0;
   assign wdt_fire    = 1'b0;
   assign wdt_err_out = WDT_TIE;
`endif

   sat_counter #(.WIDTH(16), .SATURATE(1'b0)) u_frame_cnt (
      .clk   (clk_in),
      .rst_n (rst_n_in),
      .inc   (frame_end),
      .count (frame_count_out)
   );

   sat_counter #(.WIDTH(16), .SATURATE(1'b1)) u_short_cnt (
      .clk   (clk_in),
      .rst_n (rst_n_in),
      .inc   (short_evt),
      .count (short_count_out)
   );

   sat_counter #(.WIDTH(16), .SATURATE(1'b1)) u_long_cnt (
      .clk   (clk_in),
      .rst_n (rst_n_in),
      .inc   (long_evt),
      .count (long_count_out)
   );

endmodule

// File: tb/tb_csi_frame_sequencer.sv
// Bench for csi_frame_sequencer: random frames against a frame-level reference model.
// Inputs driven 1ns after the rising edge, handshakes recorded on the falling edge.
// CSI_SEQ_WATCHDOG_EN selects the watchdog expectations.
`timescale 1ns/1ps
module tb_csi_frame_sequencer;
   import csi_pkg::*;

   localparam int NFFT = 1 << CNT_W;
   localparam int MAXF = 2;
   localparam int WDT  = 100;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] cfg_word_in;
   logic        lts_axis_tvalid, lts_axis_tlast, lts_axis_tready;
   logic [31:0] lts_axis_tdata;
   logic        fft_axis_tvalid, fft_axis_tlast, fft_axis_tready;
   logic [31:0] fft_axis_tdata;
   logic        cfg_axis_tvalid, cfg_axis_tready;
   logic [15:0] cfg_axis_tdata;
   logic        csi_done_in;
   logic [3:0]  inflight_out;
   logic [15:0] frame_count_out, short_count_out, long_count_out;
   logic        wdt_err_out;

   always #5 clk = ~clk;

   csi_frame_sequencer #(.NFFT(NFFT), .MAX_INFLIGHT(MAXF), .CFG_WIDTH(16), .WDT_CYCLES(WDT)) dut (
      .clk_in(clk), .rst_n_in(rst_n), .cfg_word_in(cfg_word_in),
      .lts_axis_tvalid(lts_axis_tvalid), .lts_axis_tlast(lts_axis_tlast),
      .lts_axis_tdata(lts_axis_tdata), .lts_axis_tready(lts_axis_tready),
      .fft_axis_tvalid(fft_axis_tvalid), .fft_axis_tlast(fft_axis_tlast),
      .fft_axis_tdata(fft_axis_tdata), .fft_axis_tready(fft_axis_tready),
      .cfg_axis_tvalid(cfg_axis_tvalid), .cfg_axis_tdata(cfg_axis_tdata),
      .cfg_axis_tready(cfg_axis_tready), .csi_done_in(csi_done_in),
      .inflight_out(inflight_out), .frame_count_out(frame_count_out),
      .short_count_out(short_count_out), .long_count_out(long_count_out),
      .wdt_err_out(wdt_err_out)
   );

   int total = 0;
   int bad   = 0;
   bit rnd_ready = 1'b0;
   bit gaps = 1'b0;
   bit stuck = 1'b0;

   logic [31:0] sent_q[$];
   logic [31:0] out_dat[$];
   logic        out_last[$];
   logic [15:0] cfg_q[$];
   int          cfg_stamp[$];
   int          beats_seen = 0;
   int          drained = 0;
   int          e_frames = 0, e_short = 0, e_long = 0;

   // Reference: outstanding frames = delivered - retired, floored at zero; optional timeout flush.
   int m_inflight = 0;
   int m_busy = 0;
   bit m_wdt = 1'b0;

   always @(negedge clk) begin
      bit hs, fe, dn;
      int nxt;
      hs = fft_axis_tvalid && fft_axis_tready;
      fe = hs && ((beats_seen % NFFT) == NFFT - 1);
      dn = csi_done_in;
      if (hs) begin
         out_dat.push_back(fft_axis_tdata);
         out_last.push_back(fft_axis_tlast);
         beats_seen++;
      end
      if (cfg_axis_tvalid && cfg_axis_tready) begin
         cfg_q.push_back(cfg_axis_tdata);
         cfg_stamp.push_back(beats_seen);
      end
      if (lts_axis_tvalid && lts_axis_tready && !fft_axis_tvalid) drained++;
      if (!rst_n) begin
         m_inflight = 0; m_busy = 0; m_wdt = 1'b0;
      end else begin
         nxt = m_inflight + (fe ? 1 : 0) - ((dn && m_inflight > 0) ? 1 : 0);
`ifdef CSI_SEQ_WATCHDOG_EN
         if (m_inflight > 0 && !dn) begin
            m_busy++;
            if (m_busy == WDT) begin
               nxt = fe ? 1 : 0; m_wdt = 1'b1; m_busy = 0;
            end
         end else begin
            m_busy = 0;
         end
`endif
         m_inflight = nxt;
      end
   end

   // FFT ready: random throttling or always ready.
   initial begin
      fft_axis_tready = 1'b0;
      forever begin
         @(posedge clk); #1;
         fft_axis_tready = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
   end

   // Hard stop so a wedged design still reaches the summary line.
   initial begin
      #800000;
      bad++; total++;
      $display("FAIL global_timeout got=running want=finished");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   task automatic tick(input int n = 1);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic push(input logic [31:0] d, input logic last);
      int g = 0;
      if (stuck) return;
      if (gaps && $urandom_range(0, 3) == 0) tick($urandom_range(1, 3));
      lts_axis_tvalid = 1'b1; lts_axis_tdata = d; lts_axis_tlast = last;
      @(negedge clk);
      while (!lts_axis_tready && g < 3000) begin @(negedge clk); g++; end
      if (g >= 3000) begin
         stuck = 1'b1; bad++; total++;
         $display("FAIL push_timeout got=tready_low want=accepted");
      end
      @(posedge clk); #1;
      lts_axis_tvalid = 1'b0; lts_axis_tlast = 1'b0;
   endtask

   task automatic send_frame(input int len);
      logic [31:0] d;
      sent_q = {};
      for (int k = 0; k < len; k++) begin
         d = $urandom;
         sent_q.push_back(d);
         push(d, k == len - 1);
      end
      e_frames++;
      if (len < NFFT) e_short++;
      if (len > NFFT) e_long++;
   endtask

   task automatic wait_beats(input int n);
      int g = 0;
      while (out_dat.size() < n && g < 2000) begin tick(); g++; end
      if (out_dat.size() < n) begin
         bad++; total++;
         $display("FAIL wait_beats got=%0d want=%0d", out_dat.size(), n);
      end
   endtask

   task automatic retire();
      csi_done_in = 1'b1; tick(); csi_done_in = 1'b0;
   endtask

   // Expected frame: the first NFFT sent samples, zero filled, tlast only on the final beat.
   function automatic int frame_errs();
      int e = 0;
      logic [31:0] ed;
      logic el;
      for (int k = 0; k < NFFT; k++) begin
         ed = (k < sent_q.size()) ? sent_q[k] : 32'h0;
         el = (k == NFFT - 1);
         if (out_dat.size() == 0) begin
            e++;
         end else begin
            if (out_dat[0] !== ed || out_last[0] !== el) e++;
            void'(out_dat.pop_front());
            void'(out_last.pop_front());
         end
      end
      return e + out_dat.size();
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      tick(4); #1;
      if ({cfg_axis_tvalid, cfg_axis_tdata, lts_axis_tready, fft_axis_tvalid, fft_axis_tlast, fft_axis_tdata} !== '0) begin
         bad++; $display("FAIL reset_ctrl got=%0h want=0",
            {cfg_axis_tvalid, cfg_axis_tdata, lts_axis_tready, fft_axis_tvalid, fft_axis_tlast, fft_axis_tdata});
      end
      total++;
      if ({inflight_out, frame_count_out, short_count_out, long_count_out, wdt_err_out} !== '0) begin
         bad++; $display("FAIL reset_status got=%0h want=0",
            {inflight_out, frame_count_out, short_count_out, long_count_out, wdt_err_out});
      end
      total++;
   endtask

   task automatic test_config();
      int g = 0;
      rst_n = 1'b1;
      tick(3); #1;
      if ({cfg_axis_tvalid, cfg_axis_tdata} !== {1'b1, CSI_FFT_CFG_DEFAULT}) begin
         bad++; $display("FAIL cfg_present got=%0h want=%0h", {cfg_axis_tvalid, cfg_axis_tdata}, {1'b1, CSI_FFT_CFG_DEFAULT});
      end
      total++;
      cfg_axis_tready = 1'b1;
      while (cfg_q.size() < 1 && g < 50) begin tick(); g++; end
      tick(5);
      if (cfg_q.size() !== 1 || (cfg_q.size() > 0 && cfg_q[0] !== CSI_FFT_CFG_DEFAULT)) begin
         bad++; $display("FAIL cfg_beat got=%0d beats want=1 beat of %0h", cfg_q.size(), CSI_FFT_CFG_DEFAULT);
      end
      total++;
   endtask

   task automatic test_normal();
      int e;
      rnd_ready = 1'b1; gaps = 1'b1;
      send_frame(NFFT);
      wait_beats(NFFT);
      e = frame_errs();
      if (e !== 0) begin bad++; $display("FAIL normal_frame got=%0d bad beats want=0", e); end
      total++;
      if (frame_count_out !== 16'(e_frames) || inflight_out !== 4'd1) begin
         bad++; $display("FAIL normal_counts got=%0d/%0d want=%0d/1", frame_count_out, inflight_out, e_frames);
      end
      total++;
      retire(); #1;
      if (inflight_out !== 4'd0) begin bad++; $display("FAIL normal_retire got=%0d want=0", inflight_out); end
      total++;
   endtask

   task automatic test_short();
      int e, rdy_hi = 0, g = 0;
      send_frame(40);
      while (out_dat.size() < NFFT && g < 2000) begin
         #1; if (lts_axis_tready) rdy_hi++;
         tick(); g++;
      end
      if (rdy_hi !== 0) begin bad++; $display("FAIL pad_tready got=%0d high cycles want=0", rdy_hi); end
      total++;
      e = frame_errs();
      if (e !== 0) begin bad++; $display("FAIL short_frame got=%0d bad beats want=0", e); end
      total++;
      if (short_count_out !== 16'(e_short) || frame_count_out !== 16'(e_frames)) begin
         bad++; $display("FAIL short_counts got=%0d/%0d want=%0d/%0d", short_count_out, frame_count_out, e_short, e_frames);
      end
      total++;
      retire();
   endtask

   task automatic test_long();
      int e;
      drained = 0;
      send_frame(70);
      wait_beats(NFFT);
      tick(2);
      e = frame_errs();
      if (e !== 0) begin bad++; $display("FAIL long_frame got=%0d bad beats want=0", e); end
      total++;
      if (drained !== 6 || long_count_out !== 16'(e_long)) begin
         bad++; $display("FAIL long_drain got=%0d/%0d want=6/%0d", drained, long_count_out, e_long);
      end
      total++;
      retire();
   endtask

   task automatic test_back_to_back();
      int e;
      rnd_ready = 1'b0; gaps = 1'b0;
      tick(2);
      for (int f = 0; f < 2; f++) begin
         send_frame(NFFT);
         wait_beats(NFFT);
         e = frame_errs();
         if (e !== 0) begin bad++; $display("FAIL b2b_frame%0d got=%0d bad beats want=0", f, e); end
         total++;
      end
      fork
         send_frame(NFFT);
         begin
            tick(10); #1;
            if (lts_axis_tready !== 1'b0 || out_dat.size() !== 0 || inflight_out !== 4'(MAXF)) begin
               bad++; $display("FAIL b2b_hold got=rdy%0d beats%0d inflight%0d want=rdy0 beats0 inflight%0d",
                  lts_axis_tready, out_dat.size(), inflight_out, MAXF);
            end
            total++;
            retire();
         end
      join
      wait_beats(NFFT);
      e = frame_errs();
      if (e !== 0) begin bad++; $display("FAIL b2b_frame2 got=%0d bad beats want=0", e); end
      total++;
      if (inflight_out !== 4'd2 || inflight_out !== 4'(m_inflight)) begin
         bad++; $display("FAIL b2b_inflight got=%0d want=2 (model %0d)", inflight_out, m_inflight);
      end
      total++;
      retire(); retire(); #1;
      if (inflight_out !== 4'd0 || frame_count_out !== 16'(e_frames)) begin
         bad++; $display("FAIL b2b_drain got=%0d/%0d want=0/%0d", inflight_out, frame_count_out, e_frames);
      end
      total++;
   endtask

   task automatic test_cfg_change();
      int e, g = 0;
      rnd_ready = 1'b1; gaps = 1'b1;
      fork
         send_frame(NFFT);
         begin tick(10); cfg_word_in = 16'h0000; end
      join
      wait_beats(NFFT);
      e = frame_errs();
      if (e !== 0) begin bad++; $display("FAIL cfgchg_frame got=%0d bad beats want=0", e); end
      total++;
      while (cfg_q.size() < 2 && g < 100) begin tick(); g++; end
      if (cfg_q.size() !== 2 || cfg_q[cfg_q.size()-1] !== 16'h0000 || cfg_stamp[cfg_stamp.size()-1] !== e_frames * NFFT) begin
         bad++; $display("FAIL cfgchg_beat got=%0d beats last=%0h at %0d want=2 beats last=0 at %0d",
            cfg_q.size(), cfg_q[cfg_q.size()-1], cfg_stamp[cfg_stamp.size()-1], e_frames * NFFT);
      end
      total++;
      retire();
      send_frame(NFFT);
      wait_beats(NFFT);
      e = frame_errs();
      if (e !== 0 || cfg_q.size() !== 2) begin bad++; $display("FAIL cfgchg_next got=%0d bad/%0d cfg want=0/2", e, cfg_q.size()); end
      total++;
      retire();
   endtask

   task automatic test_random();
      int lens[$];
      int e;
      lens = {1, NFFT - 1, NFFT + 1};
      for (int k = 0; k < 4; k++) lens.push_back($urandom_range(1, 90));
      foreach (lens[k]) begin
         drained = 0;
         send_frame(lens[k]);
         wait_beats(NFFT);
         tick(2);
         e = frame_errs();
         if (e !== 0 || (lens[k] > NFFT && drained !== lens[k] - NFFT)) begin
            bad++; $display("FAIL rand_len%0d got=%0d bad beats drained=%0d want=0 drained=%0d",
               lens[k], e, drained, (lens[k] > NFFT) ? lens[k] - NFFT : 0);
         end
         total++;
         retire();
      end
      if (frame_count_out !== 16'(e_frames) || short_count_out !== 16'(e_short) || long_count_out !== 16'(e_long)) begin
         bad++; $display("FAIL rand_counts got=%0d/%0d/%0d want=%0d/%0d/%0d",
            frame_count_out, short_count_out, long_count_out, e_frames, e_short, e_long);
      end
      total++;
   endtask

   task automatic test_watchdog();
      rnd_ready = 1'b0; gaps = 1'b0;
      tick(2);
      send_frame(NFFT);
      wait_beats(NFFT);
      void'(frame_errs());
      tick(95);
      if (inflight_out !== 4'd1 || wdt_err_out !== 1'b0) begin
         bad++; $display("FAIL wdt_early got=%0d/%0d want=1/0", inflight_out, wdt_err_out);
      end
      total++;
      tick(10);
`ifdef CSI_SEQ_WATCHDOG_EN
      if (inflight_out !== 4'd0 || wdt_err_out !== 1'b1) begin
         bad++; $display("FAIL wdt_fire got=%0d/%0d want=0/1", inflight_out, wdt_err_out);
      end
`else
      if (inflight_out !== 4'd1 || wdt_err_out !== 1'b0) begin
         bad++; $display("FAIL wdt_absent got=%0d/%0d want=1/0", inflight_out, wdt_err_out);
      end
`endif
      total++;
      if (inflight_out !== 4'(m_inflight) || wdt_err_out !== m_wdt) begin
         bad++; $display("FAIL wdt_model got=%0d/%0d want=%0d/%0d", inflight_out, wdt_err_out, m_inflight, m_wdt);
      end
      total++;
      retire(); #1;
      if (inflight_out !== 4'd0) begin bad++; $display("FAIL wdt_retire got=%0d want=0", inflight_out); end
      total++;
   endtask

   initial begin
      rst_n = 1'b0;
      cfg_word_in = CSI_FFT_CFG_DEFAULT;
      lts_axis_tvalid = 1'b0; lts_axis_tlast = 1'b0; lts_axis_tdata = '0;
      cfg_axis_tready = 1'b0;
      csi_done_in = 1'b0;
      test_reset();
      test_config();
      test_normal();
      test_short();
      test_long();
      test_back_to_back();
      test_cfg_change();
      test_random();
      test_watchdog();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
